// File: rtl/alu_nbit_seq_pkg.sv
// alu_pkg: shared constants for the sequential ALU.
//   - ALU_* : 4-bit operation codes carried on i_ctrl
//   - state_e : control FSM states (IDLE accepts work, MUL iterates a multiply)
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_MUL = 4'b1000;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_nbit_seq_if.sv
// alu_nbit_seq_if: request/response bundle between the operand muxes, the ALU
// and the writeback path.
//   Request : i_valid, i_A, i_B, i_ctrl (requester -> ALU), o_ready (ALU -> requester)
//   Response: o_valid, o_result, o_zero, o_carry, o_overflow, o_busy (ALU -> consumer)
//
// Handshake: a request transfers on a rising clock edge where i_valid and
// o_ready are both high. While i_valid is high and o_ready is low the
// requester holds i_A/i_B/i_ctrl stable; nothing is consumed. The response
// side has no backpressure: o_valid is a single-cycle pulse that the
// consumer must take in that cycle, one pulse per accepted request, in
// issue order.
interface alu_nbit_seq_if #(
    parameter int WIDTH = 32
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_A;
    logic [WIDTH-1:0] i_B;
    logic [3:0]       i_ctrl;
    logic             o_valid;
    logic [WIDTH-1:0] o_result;
    logic             o_zero;
    logic             o_carry;
    logic             o_overflow;
    logic             o_busy;

    // Requester side (operand muxes / writeback in the pipeline, the bench here).
    modport master (
        output i_valid, i_A, i_B, i_ctrl,
        input  o_ready, o_valid, o_result, o_zero, o_carry, o_overflow, o_busy
    );

    // ALU side.
    modport slave (
        input  i_valid, i_A, i_B, i_ctrl,
        output o_ready, o_valid, o_result, o_zero, o_carry, o_overflow, o_busy
    );
endinterface

// File: rtl/alu_nbit_seq_core.sv
// alu_core: combinational single-cycle ALU operations and flags.
//   a, b      : operands
//   ctrl      : op code (ALU_* in alu_pkg); MUL and unknown codes give 0
//   result    : operation result
//   zero      : result == 0
//   carry     : adder carry-out, ADD/SUB only
//   overflow  : signed overflow, ADD/SUB only
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ctrl,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] low;       // {carry into MSB, sum of bits W-2..0}
    logic             c_msb_in;
    logic             c_msb_out;
    logic [WIDTH-1:0] sum;
    logic             ovf;

    // SUB and SLT share the adder as A + ~B + 1.
    assign sub   = (ctrl == ALU_SUB) || (ctrl == ALU_SLT);
    assign b_eff = sub ? ~b : b;

    // Split the adder at the MSB so the carry into the MSB is visible;
    // signed overflow is that carry XOR the carry out of the MSB.
    assign low       = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + WIDTH'(sub);
    assign c_msb_in  = low[WIDTH-1];
    assign c_msb_out = (a[WIDTH-1] & b_eff[WIDTH-1]) |
                       (c_msb_in & (a[WIDTH-1] ^ b_eff[WIDTH-1]));
    assign sum       = {a[WIDTH-1] ^ b_eff[WIDTH-1] ^ c_msb_in, low[WIDTH-2:0]};
    assign ovf       = c_msb_in ^ c_msb_out;

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (ctrl)
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_NOR: result = ~(a | b);
            ALU_ADD, ALU_SUB: begin
                result   = sum;
                carry    = c_msb_out;
                overflow = ovf;
            end
            // Signed less-than: true sign of A-B after overflow correction.
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
            default: result = '0;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/alu_nbit_seq.sv
// alu_nbit_seq: execution-stage ALU with single-cycle ops and an iterative
// shift-add multiply.
//   i_clk, i_rst_n : clock (rising edge), asynchronous active-low reset
//   bus            : alu_nbit_seq_if slave (request handshake + registered response)
//   o_dbg_state    : current FSM state
//   o_dbg_count    : multiply iteration counter
// Single-cycle ops are registered one cycle after accept. A multiply holds
// o_ready low for WIDTH cycles while one partial product per cycle is folded
// into a 2*WIDTH accumulator.
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    alu_nbit_seq_if.slave             bus,
    output state_e                    o_dbg_state,
    output logic [$clog2(WIDTH)-1:0]  o_dbg_count
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e              state_q;
    state_e              state_d;

    logic [WIDTH-1:0]    mcand_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [2*WIDTH-1:0]  acc_q;
    logic [2*WIDTH-1:0]  addend;
    logic [2*WIDTH-1:0]  acc_next;
    logic [CW-1:0]       count_q;

    logic                valid_q;
    logic [WIDTH-1:0]    result_q;
    logic                zero_q;
    logic                carry_q;
    logic                ovf_q;

    logic                ready;
    logic                accept;
    logic                is_mul;
    logic                mul_last;

    logic [WIDTH-1:0]    core_result;
    logic                core_zero;
    logic                core_carry;
    logic                core_ovf;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (bus.i_A),
        .b        (bus.i_B),
        .ctrl     (bus.i_ctrl),
        .result   (core_result),
        .zero     (core_zero),
        .carry    (core_carry),
        .overflow (core_ovf)
    );

    assign ready    = (state_q == S_IDLE);
    assign accept   = bus.i_valid && ready;
    // With MUL_EN=0 the MUL code falls through the core as an unknown op.
    assign is_mul   = MUL_EN && (bus.i_ctrl == ALU_MUL);
    assign mul_last = (state_q == S_MUL) && (count_q == LAST);

    assign addend   = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << count_q) : '0;
    assign acc_next = acc_q + addend;

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && is_mul) state_d = S_MUL;
            S_MUL:   if (mul_last)         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand/accumulator registers and registered response.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (accept && !is_mul) begin
                valid_q  <= 1'b1;
                result_q <= core_result;
                zero_q   <= core_zero;
                carry_q  <= core_carry;
                ovf_q    <= core_ovf;
            end

            if (accept && is_mul) begin
                mcand_q  <= bus.i_A;
                mplier_q <= bus.i_B;
                acc_q    <= '0;
                count_q  <= '0;
            end

            if (state_q == S_MUL) begin
                acc_q    <= acc_next;
                mplier_q <= mplier_q >> 1;
                count_q  <= count_q + CW'(1);
                // The add on the last count completes the product.
                if (mul_last) begin
                    valid_q  <= 1'b1;
                    result_q <= acc_next[WIDTH-1:0];
                    zero_q   <= (acc_next[WIDTH-1:0] == '0);
                    carry_q  <= 1'b0;
                    ovf_q    <= |acc_next[2*WIDTH-1:WIDTH];
                    count_q  <= '0;
                end
            end
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_busy     = (state_q == S_MUL);
    assign bus.o_valid    = valid_q;
    assign bus.o_result   = result_q;
    assign bus.o_zero     = zero_q;
    assign bus.o_carry    = carry_q;
    assign bus.o_overflow = ovf_q;

    assign o_dbg_state    = state_q;
    assign o_dbg_count    = count_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
module tb_alu_nbit_seq;
    import alu_pkg::*;

    localparam int W  = 8;
    localparam int EW = W + 3;   // {result, zero, carry, overflow}

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [EW-1:0] exp0_q[$];
    int            exp0_cyc_q[$];

    alu_nbit_seq_if #(.WIDTH(W)) bus  ();
    alu_nbit_seq_if #(.WIDTH(W)) bus0 ();

    state_e     dbg_state, dbg0_state;
    logic [2:0] dbg_count, dbg0_count;

    alu_nbit_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_dbg_state(dbg_state), .o_dbg_count(dbg_count)
    );

    alu_nbit_seq #(.WIDTH(W), .MUL_EN(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus0),
        .o_dbg_state(dbg0_state), .o_dbg_count(dbg0_count)
    );

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic z, c, v);
        return {r, z, c, v};
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic logic [EW-1:0] ref_model(input logic [W-1:0] a, b, input logic [3:0] op);
        int ua, ub, sa, sb, r;
        longint p;
        logic [W-1:0] res;
        logic c, v;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        res = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b1100: res = ~(a | b);
            4'b0010: begin
                r = ua + ub; res = r[W-1:0];
                c = (r >= (1 << W));
                v = (sa + sb > (1 << (W-1)) - 1) || (sa + sb < -(1 << (W-1)));
            end
            4'b0110: begin
                r = ua - ub; res = r[W-1:0];
                c = (ua >= ub);
                v = (sa - sb > (1 << (W-1)) - 1) || (sa - sb < -(1 << (W-1)));
            end
            4'b0111: res = (sa < sb) ? W'(1) : '0;
            4'b1000: begin
                p = longint'(ua) * longint'(ub);
                res = p[W-1:0];
                v = ((p >> W) != 0);
            end
            default: res = '0;
        endcase
        return {res, (res == '0), c, v};
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; holds the request until accepted.
    task automatic issue(input bit to0, input logic [W-1:0] a, b, input logic [3:0] op,
                         input logic [EW-1:0] expv, output int acc_cyc);
        logic rdy;
        int   budget;
        budget  = 0;
        acc_cyc = -1;
        if (to0) begin
            bus0.i_valid = 1'b1; bus0.i_A = a; bus0.i_B = b; bus0.i_ctrl = op;
        end else begin
            bus.i_valid = 1'b1; bus.i_A = a; bus.i_B = b; bus.i_ctrl = op;
        end
        while (acc_cyc < 0 && budget < 100) begin
            rdy = to0 ? bus0.o_ready : bus.o_ready;
            @(posedge clk); #1;
            budget++;
            if (rdy) acc_cyc = cyc;
        end
        if (to0) bus0.i_valid = 1'b0; else bus.i_valid = 1'b0;
        if (acc_cyc < 0) begin
            check("issue_timeout", 64'd0, 64'd1);
        end else if (to0) begin
            exp0_q.push_back(expv);
            exp0_cyc_q.push_back(acc_cyc);
        end else begin
            exp_q.push_back(expv);
            exp_cyc_q.push_back(acc_cyc + ((op == ALU_MUL) ? W : 0));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- scoreboard monitors ----------------
    logic [EW-1:0] m_e, m0_e;
    int            m_c, m0_c;

    always @(negedge clk) begin
        if (bus.o_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                check("dut_unexpected_valid", 64'(bus.o_valid), 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                m_c = exp_cyc_q.pop_front();
                check("dut_resp", 64'({bus.o_result, bus.o_zero, bus.o_carry, bus.o_overflow}), 64'(m_e));
                check("dut_latency", 64'(cyc), 64'(m_c));
            end
        end
    end

    always @(negedge clk) begin
        if (bus0.o_valid !== 1'b0) begin
            if (exp0_q.size() == 0) begin
                check("dut0_unexpected_valid", 64'(bus0.o_valid), 64'd0);
            end else begin
                m0_e = exp0_q.pop_front();
                m0_c = exp0_cyc_q.pop_front();
                check("dut0_resp", 64'({bus0.o_result, bus0.o_zero, bus0.o_carry, bus0.o_overflow}), 64'(m0_e));
                check("dut0_latency", 64'(cyc), 64'(m0_c));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int ac, m_acc, a_acc, budget;
        logic [3:0] ops [9];
        logic [W-1:0] corner [4];
        logic [W-1:0] ra, rb;
        logic [3:0] rop;

        ops    = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1111, 4'b0011};
        corner = '{8'h00, 8'h7F, 8'h80, 8'hFF};

        bus.i_valid  = 1'b0; bus.i_A  = '0; bus.i_B  = '0; bus.i_ctrl  = '0;
        bus0.i_valid = 1'b0; bus0.i_A = '0; bus0.i_B = '0; bus0.i_ctrl = '0;

        // Reset held with live requests: nothing accepted, outputs at reset values.
        for (int i = 0; i < 4; i++) begin
            bus.i_valid = 1'b1; bus.i_A = W'($urandom); bus.i_B = W'($urandom);
            bus.i_ctrl = (i % 2 == 0) ? ALU_MUL : ALU_ADD;
            @(posedge clk); #1;
            check("reset_ready", 64'(bus.o_ready), 64'd1);
            check("reset_outputs", 64'({bus.o_valid, bus.o_result, bus.o_zero, bus.o_carry,
                                        bus.o_overflow, bus.o_busy}), 64'd0);
            check("reset_state", 64'(dbg_state), 64'(S_IDLE));
            check("reset_count", 64'(dbg_count), 64'd0);
        end
        bus.i_valid = 1'b0;
        rst_n = 1'b1;
        idle(1);

        // Arithmetic flags, then logic/compare, all back-to-back.
        issue(0, 8'h7F, 8'h01, ALU_ADD, pk(8'h80, 0, 0, 1), ac);
        issue(0, 8'h05, 8'h05, ALU_SUB, pk(8'h00, 1, 1, 0), ac);
        issue(0, 8'hF0, 8'h3C, ALU_AND, pk(8'h30, 0, 0, 0), ac);
        issue(0, 8'hF0, 8'h3C, ALU_OR,  pk(8'hFC, 0, 0, 0), ac);
        issue(0, 8'hF0, 8'h3C, ALU_NOR, pk(8'h03, 0, 0, 0), ac);
        issue(0, 8'hFF, 8'h01, ALU_SLT, pk(8'h01, 0, 0, 0), ac);
        issue(0, 8'h03, 8'h0A, ALU_SUB, pk(8'hF9, 0, 0, 0), ac);
        idle(2);

        // Multiply: ready low for exactly W cycles after accept.
        issue(0, 8'h0C, 8'h0B, ALU_MUL, pk(8'h84, 0, 0, 0), ac);
        for (int i = 0; i < W; i++) begin
            check("mul_ready_low", 64'(bus.o_ready), 64'd0);
            check("mul_busy_high", 64'(bus.o_busy), 64'd1);
            idle(1);
        end
        check("mul_ready_back", 64'(bus.o_ready), 64'd1);
        check("mul_busy_clear", 64'(bus.o_busy), 64'd0);
        idle(1);
        issue(0, 8'h20, 8'h10, ALU_MUL, pk(8'h00, 1, 0, 1), ac);
        idle(W + 2);

        // Held request during a multiply is taken in the MUL's o_valid cycle.
        issue(0, 8'h03, 8'h05, ALU_MUL, pk(8'h0F, 0, 0, 0), m_acc);
        issue(0, 8'h10, 8'h20, ALU_ADD, pk(8'h30, 0, 0, 0), a_acc);
        check("stall_accept_cycle", 64'(a_acc), 64'(m_acc + W + 1));
        idle(2);

        // Abort a multiply at count 3.
        issue(0, 8'hFF, 8'hFF, ALU_MUL, pk(8'h01, 0, 0, 1), ac);
        idle(3);
        check("abort_count", 64'(dbg_count), 64'd3);
        exp_q.delete();
        exp_cyc_q.delete();
        rst_n = 1'b0;
        idle(2);
        check("abort_busy", 64'(bus.o_busy), 64'd0);
        check("abort_ready", 64'(bus.o_ready), 64'd1);
        rst_n = 1'b1;
        idle(W + 2);
        issue(0, 8'h12, 8'h34, ALU_ADD, pk(8'h46, 0, 0, 0), ac);
        issue(0, 8'h5A, 8'hA5, 4'b1111, pk(8'h00, 1, 0, 0), ac);
        idle(2);

        // Multiply disabled: MUL code behaves as an unknown op.
        issue(1, 8'h0C, 8'h0B, ALU_MUL, pk(8'h00, 1, 0, 0), ac);
        issue(1, 8'h80, 8'h80, ALU_ADD, pk(8'h00, 1, 1, 1), ac);
        idle(2);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 150; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            rop = ops[$urandom_range(0, 8)];
            issue(0, ra, rb, rop, ref_model(ra, rb, rop), ac);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Drain outstanding responses.
        budget = 0;
        while ((exp_q.size() != 0 || exp0_q.size() != 0) && budget < 50) begin
            idle(1);
            budget++;
        end
        check("drain_dut", 64'(exp_q.size()), 64'd0);
        check("drain_dut0", 64'(exp0_q.size()), 64'd0);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
